// File: rtl/sram_access_arbiter.sv
// Round-robin arbiter and strobe sequencer for a 16-bit asynchronous SRAM shared by
// a read/write CPU port (A) and a read-only video fetch port (B).
module sram_access_arbiter #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              a_req_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    input  logic [1:0]        a_be_i,
    output logic              a_ack_o,
    output logic [DATA_W-1:0] a_rdata_o,
    input  logic              b_req_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    output logic              b_ack_o,
    output logic [DATA_W-1:0] b_rdata_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic              sram_lb_n_o,
    output logic              sram_ub_n_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] dq_out_o,
    output logic              dq_oe_o,
    input  logic [DATA_W-1:0] dq_in_i,
    output logic              busy_o
);

    // state  | meaning
    // IDLE   | arbitrate, latch the winner's command
    // SETUP  | address and CE valid, OE (read) or data drive (write) set up
    // ACCESS | read wait or WE low, timed by down-counter
    // DONE   | strobes released, ack pulse, write data still held
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_grant_b_q;
    logic              gnt_b_q;
    logic              wr_q;
    logic              a_ack_q, b_ack_q;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
    logic              ce_n_q, oe_n_q, we_n_q, lb_n_q, ub_n_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dq_out_q;
    logic              dq_oe_q;
    logic              busy_q;

    logic gnt_b_d;
    logic wr_d;

    // On a tie the port that did not win last time gets the bus.
    assign gnt_b_d = b_req_i & (~a_req_i | ~last_grant_b_q);
    assign wr_d    = ~gnt_b_d & a_we_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            last_grant_b_q <= 1'b1;
            gnt_b_q        <= 1'b0;
            wr_q           <= 1'b0;
            a_ack_q        <= 1'b0;
            b_ack_q        <= 1'b0;
            a_rdata_q      <= '0;
            b_rdata_q      <= '0;
            ce_n_q         <= 1'b1;
            oe_n_q         <= 1'b1;
            we_n_q         <= 1'b1;
            lb_n_q         <= 1'b1;
            ub_n_q         <= 1'b1;
            addr_q         <= '0;
            dq_out_q       <= '0;
            dq_oe_q        <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (a_req_i || b_req_i) begin
                        state_q        <= SETUP;
                        busy_q         <= 1'b1;
                        gnt_b_q        <= gnt_b_d;
                        last_grant_b_q <= gnt_b_d;
                        wr_q           <= wr_d;
                        addr_q         <= gnt_b_d ? b_addr_i : a_addr_i;
                        ce_n_q         <= 1'b0;
                        if (wr_d) begin
                            oe_n_q   <= 1'b1;
                            dq_oe_q  <= 1'b1;
                            dq_out_q <= a_wdata_i;
                            lb_n_q   <= ~a_be_i[0];
                            ub_n_q   <= ~a_be_i[1];
                            cnt_q    <= WR_LOAD;
                        end else begin
                            oe_n_q <= 1'b0;
                            lb_n_q <= 1'b0;
                            ub_n_q <= 1'b0;
                            cnt_q  <= RD_LOAD;
                        end
                    end
                end
                SETUP: begin
                    state_q <= ACCESS;
                    if (wr_q) begin
                        we_n_q <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        lb_n_q  <= 1'b1;
                        ub_n_q  <= 1'b1;
                        a_ack_q <= ~gnt_b_q;
                        b_ack_q <= gnt_b_q;
                        if (!wr_q && !gnt_b_q) begin
                            a_rdata_q <= dq_in_i;
                        end
                        if (!wr_q && gnt_b_q) begin
                            b_rdata_q <= dq_in_i;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    // Write data was held through DONE; release the bus for turnaround.
                    state_q <= IDLE;
                    dq_oe_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign a_ack_o     = a_ack_q;
    assign b_ack_o     = b_ack_q;
    assign a_rdata_o   = a_rdata_q;
    assign b_rdata_o   = b_rdata_q;
    assign sram_ce_n_o = ce_n_q;
    assign sram_oe_n_o = oe_n_q;
    assign sram_we_n_o = we_n_q;
    assign sram_lb_n_o = lb_n_q;
    assign sram_ub_n_o = ub_n_q;
    assign sram_addr_o = addr_q;
    assign dq_out_o    = dq_out_q;
    assign dq_oe_o     = dq_oe_q;
    assign busy_o      = busy_q;

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
- Sequences every access to the external 16-bit asynchronous SRAM and shares it between two requesters: port A (CPU memory control, read/write) and port B (video/display fetch, read-only).
- Grants one requester at a time using round-robin arbitration.
- Generates the active-low SRAM strobes, address and data-bus direction with fixed setup/access/turnaround timing.
- Sits between the memory control unit / video reader and the SRAM pins.
- The bidirectional SRAM_DQ tristate stays outside this block.

Parameters:
ADDR_W, 20, SRAM word-address width
DATA_W, 16, SRAM data width
RD_CYCLES, 2, cycles in ACCESS for a read (min 1)
WR_CYCLES, 2, cycles WE_N is held low in ACCESS for a write (min 1)

Ports:
Clk  in  1  system clock (single clock domain)
Reset_N  in  1  asynchronous, active-low reset
A_Req  in  1  port A request; held high until A_Ack
A_WE  in  1  port A: 1 = write, 0 = read
A_Addr  in  ADDR_W  port A address
A_WData  in  DATA_W  port A write data
A_Be  in  2  port A byte enables {UB, LB}; write only
A_Ack  out  1  one-cycle completion pulse, port A
A_RData  out  DATA_W  port A read data
B_Req  in  1  port B read request; held until B_Ack
B_Addr  in  ADDR_W  port B address
B_Ack  out  1  one-cycle completion pulse, port B
B_RData  out  DATA_W  port B read data
SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N  out  1 each  SRAM strobes
SRAM_ADDR  out  ADDR_W  SRAM address
Dq_Out  out  DATA_W  write data to tristate
Dq_OE  out  1  tristate drive enable
Dq_In  in  DATA_W  data from tristate
Busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, Reset_N low)
  - State goes to IDLE.
  - All SRAM_*_N go high; SRAM_ADDR = 0; Dq_OE = 0; Dq_Out = 0.
  - A_Ack = B_Ack = 0; A_RData = B_RData = 0.
  - last_grant = B, so A wins the first tie.
  - All outputs are registered.
- FSM states: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
- IDLE: sample requests.
  - If only one of A_Req/B_Req is high, grant it.
  - If both are high, grant the port opposite last_grant, then update last_grant.
  - Latch the granted address, write data, byte enables and direction into internal registers. Requester inputs are ignored after this point.
- SETUP (1 cycle):
  - SRAM_ADDR is valid and CE_N = 0.
  - Read: OE_N = 0, LB_N = UB_N = 0.
  - Write: OE_N = 1, Dq_OE = 1, Dq_Out valid, LB_N/UB_N = ~Be.
- ACCESS:
  - Read: lasts RD_CYCLES. Dq_In is captured into the granted port's RData at the edge ending the last ACCESS cycle.
  - Write: lasts WR_CYCLES with WE_N = 0.
- DONE (1 cycle):
  - Granted port's Ack = 1.
  - CE_N, OE_N, WE_N, LB_N and UB_N all return high.
  - Write: Dq_OE stays 1 for data hold.
  - Next state is IDLE, where Dq_OE = 0. This gives a one-cycle bus turnaround before any next access.
- Latency from Req high in IDLE to Ack: read = RD_CYCLES + 2 cycles; write = WR_CYCLES + 2 cycles. Minimum repeat period is latency + 1.
- RData holds its value until the next read completes for that port. It is valid in the Ack cycle and after.
- Handshake: the requester drops Req on the edge ending its Ack cycle. Req high in IDLE always means a new request.
- Req dropped mid-access: the access still completes and Ack still pulses; the requester ignores it. Accesses are never aborted except by reset.
- Write-enable rule: WE_N and OE_N are never low together. WE_N is low only in ACCESS.
- Reset mid-access: strobes go high immediately (asynchronously) and Dq_OE drops. No Ack is issued.
- Write with A_Be = 2'b00: the full sequence runs with LB_N = UB_N = 1, so no byte is written, and Ack still pulses.
- B never writes. WE_N stays high during any B grant.

Test Plan:
- Port A read, A_Addr = 0x00123, SRAM model returns 0xCAFE, RD_CYCLES = 2 -> Ack 4 cycles after Req seen in IDLE; A_RData = 0xCAFE; OE_N low for exactly 3 cycles; WE_N never low.
- Port A write, 0xBEEF to 0x00010, A_Be = 2'b11 -> WE_N low 2 cycles with OE_N high; Dq_OE high SETUP through DONE; read-back returns 0xBEEF.
- Byte write, A_Be = 2'b01 with 0x12AB over 0xFFFF -> UB_N = 1, LB_N = 0; read-back returns 0xFFAB.
- A_Req and B_Req both held continuously for 6 transactions -> grants alternate A, B, A, B, A, B; neither Ack stretches past one cycle; IDLE gap of 1 cycle between accesses.
- Reset_N pulsed low during a write's ACCESS -> WE_N, CE_N high and Dq_OE low in the same cycle, without waiting for a clock edge; no Ack; next A request after release wins arbitration over a simultaneous B.
- A_Req dropped during ACCESS of a read -> A_Ack still pulses once; FSM returns to IDLE and serves pending B_Req next.
